// File: rtl/eth_cmd_pkg.sv
// Shared constants, types and CRC helper for the Ethernet command receiver.
package eth_cmd_pkg;

   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   localparam logic [7:0] PRE_BYTE   = 8'h55;
   localparam logic [7:0] SFD_BYTE   = 8'hD5;
   localparam logic [7:0] BCAST_BYTE = 8'hFF;

   localparam int CMD_W = 33;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PRE   = 3'd1;
   localparam logic [2:0] ST_HDR   = 3'd2;
   localparam logic [2:0] ST_COUNT = 3'd3;
   localparam logic [2:0] ST_CMD   = 3'd4;
   localparam logic [2:0] ST_PAD   = 3'd5;
   localparam logic [2:0] ST_DROP  = 3'd6;

   localparam logic [3:0] OFS_DST_FIRST = 4'd0;
   localparam logic [3:0] OFS_DST_LAST  = 4'd5;
   localparam logic [3:0] OFS_TYPE_HI   = 4'd12;
   localparam logic [3:0] OFS_TYPE_LO   = 4'd13;
   localparam logic [3:0] OFS_COUNT     = 4'd14;

   typedef struct packed {
      logic [15:0] rsvd;
      logic        addr;
      logic [15:0] data;
   } cmd_t;

   // Reflected CRC-32, one byte, no final inversion.
   function automatic logic [31:0] crc32_byte(
      input logic [31:0] crc,
      input logic [7:0]  b
   );
      logic [31:0] c;
      c = crc ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_cmd_rx_if.sv
// Command handshake toward the SPI sensor-configuration engine.
interface eth_cmd_rx_if;
   logic [eth_cmd_pkg::CMD_W-1:0] o_cmd_data;
   logic                          o_cmd_vld;
   logic                          i_cmd_rdy;

   modport master (
      output o_cmd_data,
      output o_cmd_vld,
      input  i_cmd_rdy
   );

   modport slave (
      input  o_cmd_data,
      input  o_cmd_vld,
      output i_cmd_rdy
   );
endinterface

// File: rtl/eth_cmd_rx_fifo.sv
// Command FIFO with tentative writes that only become readable on commit.
module cmd_commit_fifo
   import eth_cmd_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic pll_clk_rx,
   input  logic rst_n,
   input  logic wr_en_i,
   input  cmd_t wr_data_i,
   input  logic commit_i,
   input  logic rollback_i,
   input  logic rd_rdy_i,
   output cmd_t rd_data_o,
   output logic rd_vld_o,
   output logic full_o,
   output logic ovf_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   cmd_t          mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] cm_q, cm_d;
   logic [PW-1:0] rd_q, rd_d;
   logic          ovf_q, ovf_d;
   logic          vld_q, vld_d;
   cmd_t          data_q, data_d;
   logic          rd_en;
   logic          wr_ok;

   assign rd_en  = vld_q & rd_rdy_i;
   // A read in the same cycle frees the slot a full write would need.
   assign full_o = ((wr_q - rd_q) == PW'(DEPTH)) & ~rd_en;
   assign wr_ok  = wr_en_i & ~full_o;

   always_comb begin
      rd_d  = rd_q + PW'(rd_en);
      wr_d  = wr_q;
      cm_d  = cm_q;
      ovf_d = ovf_q;
      if (wr_ok)            wr_d  = wr_q + PW'(1);
      if (wr_en_i & full_o) ovf_d = 1'b1;
      if (commit_i) begin
         cm_d  = wr_q;
         ovf_d = 1'b0;
      end
      if (rollback_i) begin
         wr_d  = cm_q;
         ovf_d = 1'b0;
      end
      vld_d  = (rd_d != cm_d);
      data_d = vld_d ? mem_q[rd_d[AW-1:0]] : '0;
   end

   always_ff @(posedge pll_clk_rx) begin
      if (wr_ok) mem_q[wr_q[AW-1:0]] <= wr_data_i;
   end

   always_ff @(posedge pll_clk_rx or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= '0;
         cm_q   <= '0;
         rd_q   <= '0;
         ovf_q  <= 1'b0;
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         wr_q   <= wr_d;
         cm_q   <= cm_d;
         rd_q   <= rd_d;
         ovf_q  <= ovf_d;
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign rd_data_o = data_q;
   assign rd_vld_o  = vld_q;
   assign ovf_o     = ovf_q;

endmodule

// File: rtl/eth_cmd_rx.sv
// Ethernet control-frame parser: header filter, FCS check and command queue.
module eth_cmd_rx
   import eth_cmd_pkg::*;
#(
   parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
   parameter logic [15:0] ETHERTYPE  = 16'h88B5,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        pll_clk_rx,
   input  logic        rst_n,
   input  logic [7:0]  rx_in_data,
   input  logic        rx_dv,
   eth_cmd_rx_if.master cmd,
   output logic [15:0] o_frm_ok,
   output logic [15:0] o_frm_bad
);

   logic [2:0]  state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  n_q, n_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mac_q, mac_d;
   logic        bc_q, bc_d;
   logic        flag_q, flag_d;
   logic [7:0]  hi_q, hi_d;
   logic [31:0] crc_q, crc_d;
   logic [15:0] ok_q, bad_q;

   logic [31:0] crc_nx;
   logic [7:0]  mac_b;
   logic        wr_req, commit, rollback;
   logic        ok_inc, bad_inc;
   logic        full, ovf;
   cmd_t        wr_data;
   cmd_t        rd_data;

   assign crc_nx  = crc32_byte(crc_q, rx_in_data);
   assign mac_b   = 8'(MAC_ADDR >> (6'd40 - {idx_q[2:0], 3'b000}));
   assign wr_data = '{rsvd: 16'h0, addr: flag_q, data: {hi_q, rx_in_data}};

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      n_d      = n_q;
      cnt_d    = cnt_q;
      mac_d    = mac_q;
      bc_d     = bc_q;
      flag_d   = flag_q;
      hi_d     = hi_q;
      crc_d    = crc_q;
      wr_req   = 1'b0;
      commit   = 1'b0;
      rollback = 1'b0;
      ok_inc   = 1'b0;
      bad_inc  = 1'b0;
      if (!rx_dv) begin
         state_d = ST_IDLE;
         if (state_q != ST_IDLE) begin
            if (state_q == ST_PAD && crc_q == CRC_RESIDUE && !ovf) begin
               commit = 1'b1;
               ok_inc = 1'b1;
            end else begin
               rollback = 1'b1;
               bad_inc  = ovf | (state_q == ST_PAD);
            end
         end
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (rx_in_data == PRE_BYTE) state_d = ST_PRE;
            end
            ST_PRE: begin
               if (rx_in_data == SFD_BYTE) begin
                  state_d = ST_HDR;
                  crc_d   = CRC_INIT;
                  idx_d   = OFS_DST_FIRST;
                  mac_d   = 1'b1;
                  bc_d    = 1'b1;
               end else if (rx_in_data != PRE_BYTE) begin
                  state_d = ST_DROP;
               end
            end
            ST_HDR: begin
               crc_d = crc_nx;
               idx_d = idx_q + 4'd1;
               if (idx_q <= OFS_DST_LAST) begin
                  mac_d = mac_q & (rx_in_data == mac_b);
                  bc_d  = bc_q & (rx_in_data == BCAST_BYTE);
                  if (!mac_d && !bc_d) state_d = ST_DROP;
               end else if (idx_q == OFS_TYPE_HI) begin
                  if (rx_in_data != ETHERTYPE[15:8]) state_d = ST_DROP;
               end else if (idx_q == OFS_TYPE_LO) begin
                  state_d = (rx_in_data == ETHERTYPE[7:0]) ? ST_COUNT : ST_DROP;
               end
            end
            ST_COUNT: begin
               crc_d   = crc_nx;
               n_d     = rx_in_data;
               cnt_d   = 8'd0;
               idx_d   = 4'd0;
               state_d = (rx_in_data == 8'd0) ? ST_PAD : ST_CMD;
            end
            ST_CMD: begin
               crc_d = crc_nx;
               idx_d = (idx_q == 4'd2) ? 4'd0 : idx_q + 4'd1;
               if (idx_q == 4'd0) flag_d = rx_in_data[0];
               if (idx_q == 4'd1) hi_d = rx_in_data;
               if (idx_q == 4'd2) begin
                  wr_req = 1'b1;
                  cnt_d  = cnt_q + 8'd1;
                  if (full)                     state_d = ST_DROP;
                  else if (cnt_q + 8'd1 == n_q) state_d = ST_PAD;
               end
            end
            ST_PAD: crc_d = crc_nx;
            default: ;
         endcase
      end
   end

   always_ff @(posedge pll_clk_rx or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         mac_q   <= 1'b0;
         bc_q    <= 1'b0;
         flag_q  <= 1'b0;
         hi_q    <= '0;
         crc_q   <= CRC_INIT;
         ok_q    <= '0;
         bad_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         mac_q   <= mac_d;
         bc_q    <= bc_d;
         flag_q  <= flag_d;
         hi_q    <= hi_d;
         crc_q   <= crc_d;
         if (ok_inc && ok_q != 16'hFFFF)   ok_q  <= ok_q + 16'd1;
         if (bad_inc && bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
      end
   end

   cmd_commit_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .pll_clk_rx (pll_clk_rx),
      .rst_n      (rst_n),
      .wr_en_i    (wr_req),
      .wr_data_i  (wr_data),
      .commit_i   (commit),
      .rollback_i (rollback),
      .rd_rdy_i   (cmd.i_cmd_rdy),
      .rd_data_o  (rd_data),
      .rd_vld_o   (cmd.o_cmd_vld),
      .full_o     (full),
      .ovf_o      (ovf)
   );

   assign cmd.o_cmd_data = rd_data;
   assign o_frm_ok       = ok_q;
   assign o_frm_bad      = bad_q;

endmodule

// File: tb/tb_eth_cmd_rx.sv
// Scoreboard bench for eth_cmd_rx: frames built with their own FCS.
module tb_eth_cmd_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_in_data = 8'h00;
   logic        rx_dv = 1'b0;
   logic [15:0] frm_ok;
   logic [15:0] frm_bad;

   localparam logic [47:0] MAC     = 48'h02_00_00_00_00_01;
   localparam logic [47:0] FOREIGN = 48'h02_00_00_00_00_99;
   localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
   localparam logic [15:0] ET      = 16'h88B5;

   eth_cmd_rx_if cmd_if ();

   eth_cmd_rx dut (
      .pll_clk_rx (clk),
      .rst_n      (rst_n),
      .rx_in_data (rx_in_data),
      .rx_dv      (rx_dv),
      .cmd        (cmd_if),
      .o_frm_ok   (frm_ok),
      .o_frm_bad  (frm_bad)
   );

   always #4 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_acc = 0;
   int          n_vld = 0;
   logic [32:0] exp_q [$];
   logic [7:0]  frm [$];
   logic [23:0] cmds [$];

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                           input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int k = 0; k < 8; k++) begin
         if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB8_8320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic build(input logic [47:0] dst, input logic [15:0] et,
                        input bit flip);
      logic [31:0] crc;
      frm.delete();
      for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
      for (int i = 0; i < 5; i++) frm.push_back(8'h00);
      frm.push_back(8'h0A);
      frm.push_back(et[15:8]);
      frm.push_back(et[7:0]);
      frm.push_back(8'(cmds.size()));
      foreach (cmds[i]) begin
         frm.push_back(cmds[i][23:16]);
         frm.push_back(cmds[i][15:8]);
         frm.push_back(cmds[i][7:0]);
      end
      while (frm.size() < 60) frm.push_back(8'h00);
      crc = 32'hFFFF_FFFF;
      foreach (frm[i]) crc = crc_upd(crc, frm[i]);
      crc = ~crc;
      for (int i = 0; i < 4; i++) frm.push_back(crc[8*i +: 8]);
      if (flip) frm[frm.size()-2] = frm[frm.size()-2] ^ 8'h08;
   endtask

   task automatic push_exp();
      foreach (cmds[i]) exp_q.push_back({16'h0, cmds[i][16], cmds[i][15:0]});
   endtask

   task automatic drive_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_dv      = 1'b1;
      rx_in_data = b;
   endtask

   // cut < 0: whole frame then rx_dv drops; else stop after cut bytes.
   task automatic send(input int cut);
      for (int i = 0; i < 7; i++) drive_byte(8'h55);
      drive_byte(8'hD5);
      foreach (frm[i]) begin
         if (cut >= 0 && i >= cut) break;
         drive_byte(frm[i]);
      end
      if (cut < 0) begin
         @(posedge clk);
         #1;
         rx_dv = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   always @(negedge clk) begin
      logic [32:0] e;
      if (rst_n && cmd_if.o_cmd_vld) begin
         n_vld++;
         if (cmd_if.i_cmd_rdy) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
            check("cmd", 64'(cmd_if.o_cmd_data), 64'(e));
            n_acc++;
         end
      end
   end

   initial begin
      int base;
      cmd_if.i_cmd_rdy = 1'b1;
      idle(3);
      #1;
      check("rst_vld", 64'(cmd_if.o_cmd_vld), 64'd0);
      check("rst_data", 64'(cmd_if.o_cmd_data), 64'd0);
      check("rst_ok", 64'(frm_ok), 64'd0);
      check("rst_bad", 64'(frm_bad), 64'd0);
      rst_n = 1'b1;
      idle(2);

      cmds = '{24'h01_1234, 24'h00_ABCD};
      build(MAC, ET, 1'b0);
      push_exp();
      send(-1);
      @(negedge clk);
      check("vld_early", 64'(cmd_if.o_cmd_vld), 64'd0);
      @(negedge clk);
      check("vld_lat", 64'(cmd_if.o_cmd_vld), 64'd1);
      idle(6);
      check("good_ok", 64'(frm_ok), 64'd1);
      check("good_left", 64'(exp_q.size()), 64'd0);

      base = n_vld;
      build(MAC, ET, 1'b1);
      send(-1);
      idle(6);
      check("fcs_vld", 64'(n_vld - base), 64'd0);
      check("fcs_bad", 64'(frm_bad), 64'd1);
      check("fcs_ok", 64'(frm_ok), 64'd1);

      build(FOREIGN, ET, 1'b0);
      send(-1);
      build(MAC, 16'h0800, 1'b0);
      send(-1);
      idle(4);
      check("flt_vld", 64'(n_vld - base), 64'd0);
      check("flt_ok", 64'(frm_ok), 64'd1);
      check("flt_bad", 64'(frm_bad), 64'd1);
      build(BCAST, ET, 1'b0);
      push_exp();
      send(-1);
      idle(6);
      check("bc_ok", 64'(frm_ok), 64'd2);
      check("bc_left", 64'(exp_q.size()), 64'd0);

      cmd_if.i_cmd_rdy = 1'b0;
      cmds.delete();
      for (int i = 0; i < 10; i++) cmds.push_back({7'h0, i[0], 16'h1000 + 16'(i)});
      build(MAC, ET, 1'b0);
      push_exp();
      send(-1);
      idle(2);
      cmds.delete();
      for (int i = 0; i < 10; i++) cmds.push_back({8'h01, 16'h2000 + 16'(i)});
      build(MAC, ET, 1'b0);
      send(-1);
      idle(3);
      check("ovf_ok", 64'(frm_ok), 64'd3);
      check("ovf_bad", 64'(frm_bad), 64'd2);
      check("ovf_hold", 64'(cmd_if.o_cmd_vld), 64'd1);
      base = n_acc;
      #1 cmd_if.i_cmd_rdy = 1'b1;
      idle(20);
      check("ovf_drain", 64'(n_acc - base), 64'd10);
      check("ovf_left", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check("ovf_empty", 64'(cmd_if.o_cmd_vld), 64'd0);

      base = n_acc;
      fork
         for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1 cmd_if.i_cmd_rdy = ~cmd_if.i_cmd_rdy;
         end
         for (int f = 0; f < 3; f++) begin
            cmds.delete();
            for (int i = 0; i < 4; i++)
               cmds.push_back({7'h0, i[0], 8'(f), 8'(i)});
            build(MAC, ET, 1'b0);
            push_exp();
            send(-1);
         end
      join
      cmd_if.i_cmd_rdy = 1'b1;
      idle(30);
      check("b2b_cnt", 64'(n_acc - base), 64'd12);
      check("b2b_left", 64'(exp_q.size()), 64'd0);
      check("b2b_ok", 64'(frm_ok), 64'd6);

      cmd_if.i_cmd_rdy = 1'b0;
      cmds = '{24'h01_0101, 24'h00_0202};
      build(MAC, ET, 1'b0);
      push_exp();
      send(-1);
      idle(3);
      check("pre_rst_vld", 64'(cmd_if.o_cmd_vld), 64'd1);
      cmds = '{24'h01_1111, 24'h01_2222, 24'h01_3333};
      build(MAC, ET, 1'b0);
      send(19);
      rst_n = 1'b0;
      #1;
      check("mid_rst_vld", 64'(cmd_if.o_cmd_vld), 64'd0);
      check("mid_rst_data", 64'(cmd_if.o_cmd_data), 64'd0);
      check("mid_rst_ok", 64'(frm_ok), 64'd0);
      check("mid_rst_bad", 64'(frm_bad), 64'd0);
      exp_q.delete();
      rx_dv = 1'b0;
      idle(2);
      #1;
      rst_n = 1'b1;
      cmd_if.i_cmd_rdy = 1'b1;
      cmds = '{24'h01_5A5A};
      build(MAC, ET, 1'b0);
      push_exp();
      send(-1);
      idle(6);
      check("post_rst_ok", 64'(frm_ok), 64'd1);
      check("post_rst_left", 64'(exp_q.size()), 64'd0);
      check("post_rst_vld", 64'(cmd_if.o_cmd_vld), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
